// File: rtl/reg_file_pkg.sv
// Shared constants and state encoding for the multi-port register file and its neighbours.
package reg_file_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear engine: walks every register index once, emitting a zero-write strobe per cycle.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int unsigned AddrW = DefAddrW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_req_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [AddrW-1:0] clr_idx_o
);

  clr_state_e       state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req_i) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        // Index wraps to zero on the same edge that ends the sweep.
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StClear;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o    = (state_q == StClear);
  assign clr_we_o  = busy_o;
  assign clr_idx_o = idx_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with sequential clear engine.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     RegWr,
  input  logic [ADDR_W-1:0]        WriteReg,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [NUM_RD*ADDR_W-1:0] Read,
  output logic [NUM_RD*DATA_W-1:0] Data,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic [DATA_W-1:0] rf_q [Depth];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_en;

  reg_file_clr_fsm #(
    .AddrW (ADDR_W)
  ) u_clr_fsm (
    .clk_i       (clock),
    .rst_i       (reset),
    .clear_req_i (clear_req),
    .busy_o      (busy),
    .clr_we_o    (clr_we),
    .clr_idx_o   (clr_idx)
  );

  // A clear request in the same cycle wins over the port write.
  assign wr_en = RegWr && !busy && !clear_req && !reset && !(ZeroEn && (WriteReg == '0));

  always_ff @(posedge clock) begin
    if (clr_we) begin
      rf_q[clr_idx] <= '0;
    end else if (wr_en) begin
      rf_q[WriteReg] <= WriteData;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign rd_addr = Read[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_data = rf_q[rd_addr];
`ifdef REG_FILE_BYPASS_EN
      // Only a write that will actually commit at the next edge is forwarded.
      if (wr_en && (rd_addr == WriteReg)) rd_data = WriteData;
`endif
      if (busy || (ZeroEn && (rd_addr == '0))) rd_data = '0;
    end

    assign Data[k*DATA_W +: DATA_W] = rd_data;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port register file for the multi-cycle CPU datapath; successor to the fixed 32x32, two-read-port file.
- Width, depth and read-port count are parameters.
- A sequential clear engine zeroes every entry after reset or on request, so no register holds X at start-up.
- Register 0 optionally hardwired to zero.
- Asynchronous reads; writes take effect on the rising clock edge.

Parameters:
DATA_W, 32, bits per register
ADDR_W, 5, address bits; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
RegWr  input  1  write enable
WriteReg  input  ADDR_W  write address
WriteData  input  DATA_W  write data
Read  input  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
Data  output  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
clear_req  input  1  one-cycle pulse: request full zeroing of the array
busy  output  1  high while the clear engine runs; writes are ignored

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high; it is sampled only on the rising edge of `clock`.
- State machine, two states: IDLE and CLEAR. Clear counter `clr_idx` is ADDR_W bits.
- reset high at a rising edge: state <= CLEAR, clr_idx <= 0. Holds for every cycle reset stays high. This includes reset arriving mid-clear: the sweep restarts at 0.
- CLEAR state:
  - each rising edge writes 0 to RF[clr_idx] and increments clr_idx;
  - on the edge that writes entry 2**ADDR_W-1, state <= IDLE;
  - a sweep takes exactly 2**ADDR_W cycles after reset deasserts (32 at defaults).
- IDLE with clear_req high: state <= CLEAR, clr_idx <= 0 at that edge. clear_req has priority over a same-cycle RegWr; that write is dropped.
- clear_req while in CLEAR: ignored; the sweep is not restarted.
- busy = (state == CLEAR). Combinational from state. Reset value 1.
- Write: in IDLE with RegWr=1, RF[WriteReg] <= WriteData at the rising edge. In CLEAR, RegWr is ignored.
- ZERO_REG=1: writes with WriteReg==0 are dropped. Reads of address 0 return 0 regardless of array content.
- Read: each port is combinational, Data_k = RF[Read_k]. Ports are fully independent; any two ports may use the same address.
- While busy=1, all Data outputs are forced to 0. This is defined behaviour, not X.
- Reset value of Data: 0, because busy=1.
- Write-then-read latency: a value written at edge N is visible on Data immediately after edge N.
- Same-cycle write/read of the same address without the optional feature: Data shows the old value until the edge.
- No arithmetic beyond clr_idx increment. The wrap of clr_idx from all-ones to 0 coincides with the CLEAR-to-IDLE transition.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through forwarding. In IDLE with RegWr=1, each port k where Read_k==WriteReg returns WriteData combinationally in the same cycle. Excluded: address 0 when ZERO_REG=1, and any cycle with busy=1.
- Not defined: reads return array contents only; no forwarding mux is built.

Decomposition:
- Shared package reg_file_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_CLEAR=1'b1;
  - default DATA_W/ADDR_W constants shared with the ALU and datapath.
- One natural sub-module: reg_file_clr_fsm. It holds state, clr_idx and busy, and outputs a clear-write strobe plus index.
- The top level owns the array, the write mux (clear engine vs. RegWr) and the NUM_RD read/bypass generate loop.

Test Plan:
1. Reset high 3 cycles, then low -> busy=1 for exactly 32 cycles after deassert; then busy=0 and every address 0..31 reads 0 on both ports.
2. After clear: RegWr=1, WriteReg=5, WriteData=32'hDEADBEEF; next cycle Read0=5, Read1=5 -> both Data = 32'hDEADBEEF. Then write 32'h1234 to reg 0 -> reads of 0 still return 0 (ZERO_REG=1).
3. Write regs 1..31 with value = index*3; pulse clear_req with a concurrent RegWr to reg 7 -> busy for 32 cycles, reg 7 not updated, all reads 0 afterwards.
4. Start a clear, assert reset at sweep cycle 10 -> sweep restarts; busy stays high 32 cycles after reset deasserts. Write attempts during busy have no effect.
5. With REG_FILE_BYPASS_EN: RegWr=1, WriteReg=9, WriteData=32'hA5A5A5A5, Read0=9 in the same cycle -> Data0 = 32'hA5A5A5A5 before the edge. Without the macro -> Data0 holds the old value (0) until the edge.
6. NUM_RD=4, DATA_W=16, ADDR_W=3 -> clear takes 8 cycles; four ports reading distinct written regs 1,2,3,4 (values 16'h0011..16'h0044) return correct values simultaneously.
